voice_allocator: RTL and testbench
==================================

Name: voice_allocator

Overview:
- Sits between song_reader and a bank of NUM_VOICES note_player voices inside the chords path.
- Assigns each new_note to a free voice and counts its duration down on beat.
- Frees the voice when the count expires and drives player_ready back to song_reader.
- Provides deterministic voice sharing for chords: several notes start together, each held for its own duration.

Parameters:
- NUM_VOICES, 3, number of note_player voices managed (1..8).
- NOTE_W, 6, note code width.
- DUR_W, 6, duration width in beats.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; the top level drives it with reset | reset_player.
- play  in  1  high = song running; low = paused.
- new_note  in  1  one-cycle strobe from song_reader; note/duration valid this cycle.
- note  in  NOTE_W  note code; 0 = rest.
- duration  in  DUR_W  length in beats.
- beat  in  1  one-cycle beat strobe from beat_generator.
- voice_active  out  NUM_VOICES  voice i holds a note.
- voice_play  out  NUM_VOICES  voice_active & play; enables note_player i.
- voice_load  out  NUM_VOICES  one-cycle pulse; voice i must restart phase with new note.
- voice_note  out  NUM_VOICES*NOTE_W  packed notes, voice i at [i*NOTE_W +: NOTE_W].
- player_ready  out  1  at least one voice free.
- all_idle  out  1  no voice active.
- overflow  out  1  sticky: a note was dropped for lack of a free voice.

Behaviour:
- Reset: all voices FREE, counters 0, voice_note 0, voice_active/voice_play/voice_load 0, overflow 0. player_ready and all_idle are 1 in the cycle after reset.
- Per-voice FSM, two states:
  - FREE -> ACTIVE on allocation.
  - ACTIVE -> FREE when a beat decrements the counter from 1 to 0.
- Allocation: on new_note with duration != 0, take the lowest-index voice that is FREE at the start of the cycle.
  - Load counter = duration and voice_note = note.
  - Assert voice_load[i] for exactly that cycle (registered, visible the next cycle).
  - voice_active[i] rises with voice_load[i].
- Allocation is independent of play, so song_reader can preload while paused.
- Rest notes (note 0) allocate normally and occupy a voice; note_player outputs silence for code 0.
- duration == 0: no allocation, no voice_load, no overflow; the strobe is ignored.
- No free voice on a valid new_note: note dropped, overflow set and held until reset.
- Beat while play = 1: every ACTIVE voice decrements.
  - A counter reaching 0 frees the voice.
  - voice_active falls the cycle after the beat edge.
  - voice_note keeps its last value; it is don't-care while inactive.
- Beat while play = 0: ignored. Counters freeze and voice_play is forced low.
- Simultaneous new_note and beat in one cycle:
  - The beat applies to voices ACTIVE before the cycle.
  - The newly loaded voice is not decremented: a duration-d note lives exactly d beats.
  - A voice freed by that same beat is not eligible; allocation uses the pre-cycle free mask.
- Combinational outputs (derived from registered state):
  - player_ready = ~&voice_active.
  - all_idle = ~|voice_active.
- Latency: new_note to voice_active/voice_load = 1 cycle; beat to free = 1 cycle.
- Reset mid-note: all voices FREE next cycle. No voice_load pulse is generated.

Decomposition:
- Package music_pkg holds:
  - NOTE_W, DUR_W.
  - NOTE_REST = 0.
  - The voice state enum (VOICE_FREE, VOICE_ACTIVE).
- Sub-module voice_slot: one voice's FSM, duration counter, note register and load pulse, with ports for load, beat_en and free.
- The top level instantiates NUM_VOICES slots plus a lowest-index priority encoder and the overflow flag.

Test Plan:
- Single note: reset, play=1, new_note note=20 dur=3, then 3 beats -> voice_load=001 one cycle; voice_active=001 for 3 beats; clears the cycle after the 3rd beat; all_idle returns to 1.
- Chord: three consecutive new_note (10/2, 14/4, 17/1), then beats -> voices 0, 1, 2 allocated in order; player_ready=0 after the third; voice2 frees after beat 1, voice0 after beat 2, voice1 after beat 4.
- Overflow: fill all 3 voices, then new_note 30/2 -> no voice_load, overflow=1 and stays 1; existing voice_note values unchanged.
- Same-cycle beat and new_note: voice0 counter=1, voice1 FREE; new_note 22/2 with beat -> voice0 frees, voice1 loaded with counter 2 (not decremented); voice0 is not chosen.
- Pause: active voice counter=2, play=0, 5 beats -> counter unchanged, voice_play=0, voice_active=1; play=1 plus 2 beats -> freed.
- Edge inputs: new_note dur=0 -> ignored, no flags. Reset asserted with 2 voices active -> all outputs at reset values the next cycle, player_ready=1.

Source files
------------

// File: rtl/music_pkg.sv
// Shared types and constants for the chords path: note/duration widths and
// the per-voice state encoding.
package music_pkg;

  localparam int NOTE_W = 6;
  localparam int DUR_W  = 6;

  localparam logic [NOTE_W-1:0] NOTE_REST = 6'd0;

  typedef enum logic {
    VOICE_FREE   = 1'b0,
    VOICE_ACTIVE = 1'b1
  } voice_state_t;

endpackage

// File: rtl/voice_slot.sv
// One note_player voice: FREE/ACTIVE state, beat-driven duration counter,
// held note code and a one-cycle load pulse.
module voice_slot #(
  parameter int NOTE_W = music_pkg::NOTE_W,
  parameter int DUR_W  = music_pkg::DUR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              beat_en,
  input  logic [NOTE_W-1:0] note_in,
  input  logic [DUR_W-1:0]  dur_in,
  output logic              free,
  output logic              active,
  output logic              load_pulse,
  output logic [NOTE_W-1:0] note
);
  import music_pkg::*;

  voice_state_t      r_state;
  logic [DUR_W-1:0]  r_count;
  logic [NOTE_W-1:0] r_note;
  logic              r_load_pulse;

  // Voice FSM: a load takes precedence over the beat, so a note loaded on a
  // beat cycle keeps its full duration.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= VOICE_FREE;
      r_count      <= {DUR_W{1'b0}};
      r_note       <= {NOTE_W{1'b0}};
      r_load_pulse <= 1'b0;
    end else begin
      r_load_pulse <= load;
      if (load) begin
        r_state <= VOICE_ACTIVE;
        r_count <= dur_in;
        r_note  <= note_in;
      end else if (beat_en && (r_state == VOICE_ACTIVE)) begin
        if (r_count == DUR_W'(1)) begin
          r_state <= VOICE_FREE;
          r_count <= {DUR_W{1'b0}};
        end else begin
          r_count <= r_count - DUR_W'(1);
        end
      end
    end
  end

  assign free       = (r_state == VOICE_FREE);
  assign active     = (r_state == VOICE_ACTIVE);
  assign load_pulse = r_load_pulse;
  assign note       = r_note;

endmodule

// File: rtl/voice_allocator.sv
// Assigns incoming notes to the lowest free voice, counts durations on beat
// and reports free capacity back to song_reader.
module voice_allocator #(
  parameter int NUM_VOICES = 3,
  parameter int NOTE_W     = music_pkg::NOTE_W,
  parameter int DUR_W      = music_pkg::DUR_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         play,
  input  logic                         new_note,
  input  logic [NOTE_W-1:0]            note,
  input  logic [DUR_W-1:0]             duration,
  input  logic                         beat,
  output logic [NUM_VOICES-1:0]        voice_active,
  output logic [NUM_VOICES-1:0]        voice_play,
  output logic [NUM_VOICES-1:0]        voice_load,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
  output logic                         player_ready,
  output logic                         all_idle,
  output logic                         overflow
);
  import music_pkg::*;

  logic [NUM_VOICES-1:0] w_free;
  logic [NUM_VOICES-1:0] w_grant;
  logic                  w_found;
  logic                  w_valid;
  logic                  w_beat_en;
  logic                  r_overflow;

  assign w_valid   = new_note && (duration != {DUR_W{1'b0}});
  assign w_beat_en = beat && play;

  // Lowest-index priority encoder over the pre-cycle free mask.
  always_comb begin
    w_grant = {NUM_VOICES{1'b0}};
    w_found = 1'b0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (w_valid && !w_found && w_free[i]) begin
        w_grant[i] = 1'b1;
        w_found    = 1'b1;
      end else begin
        w_grant[i] = w_grant[i];
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_VOICES; g++) begin : g_slot
      voice_slot #(
        .NOTE_W (NOTE_W),
        .DUR_W  (DUR_W)
      ) u_slot (
        .clk        (clk),
        .reset      (reset),
        .load       (w_grant[g]),
        .beat_en    (w_beat_en),
        .note_in    (note),
        .dur_in     (duration),
        .free       (w_free[g]),
        .active     (voice_active[g]),
        .load_pulse (voice_load[g]),
        .note       (voice_note[g*NOTE_W +: NOTE_W])
      );
    end
  endgenerate

  // Sticky drop flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_valid && (w_free == {NUM_VOICES{1'b0}})) begin
      r_overflow <= 1'b1;
    end else begin
      r_overflow <= r_overflow;
    end
  end

  assign overflow     = r_overflow;
  assign voice_play   = voice_active & {NUM_VOICES{play}};
  assign player_ready = ~&voice_active;
  assign all_idle     = ~|voice_active;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed self-checking bench for voice_allocator (3 voices).
module tb_voice_allocator;

  logic        clk = 1'b0;
  logic        reset;
  logic        play;
  logic        new_note;
  logic [5:0]  note;
  logic [5:0]  duration;
  logic        beat;
  logic [2:0]  voice_active;
  logic [2:0]  voice_play;
  logic [2:0]  voice_load;
  logic [17:0] voice_note;
  logic        player_ready;
  logic        all_idle;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  voice_allocator #(.NUM_VOICES(3), .NOTE_W(6), .DUR_W(6)) dut (
    .clk          (clk),
    .reset        (reset),
    .play         (play),
    .new_note     (new_note),
    .note         (note),
    .duration     (duration),
    .beat         (beat),
    .voice_active (voice_active),
    .voice_play   (voice_play),
    .voice_load   (voice_load),
    .voice_note   (voice_note),
    .player_ready (player_ready),
    .all_idle     (all_idle),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply current inputs for one clock, then release strobes and settle.
  task automatic step();
    @(posedge clk);
    #1;
    new_note = 1'b0;
    beat     = 1'b0;
  endtask

  task automatic give_note(input logic [5:0] n, input logic [5:0] d);
    new_note = 1'b1;
    note     = n;
    duration = d;
    step();
  endtask

  task automatic give_beat();
    beat = 1'b1;
    step();
  endtask

  initial begin
    reset = 1'b1; play = 1'b0; new_note = 1'b0; note = 6'd0; duration = 6'd0; beat = 1'b0;
    step(); step();
    reset = 1'b0;
    chk("rst_active", 32'(voice_active), 32'd0);
    chk("rst_load",   32'(voice_load),   32'd0);
    chk("rst_play",   32'(voice_play),   32'd0);
    chk("rst_note",   32'(voice_note),   32'd0);
    chk("rst_ready",  32'(player_ready), 32'd1);
    chk("rst_idle",   32'(all_idle),     32'd1);
    chk("rst_ovf",    32'(overflow),     32'd0);

    // Single note 20/3
    play = 1'b1;
    give_note(6'd20, 6'd3);
    chk("s_load",   32'(voice_load),       32'd1);
    chk("s_active", 32'(voice_active),     32'd1);
    chk("s_play",   32'(voice_play),       32'd1);
    chk("s_note",   32'(voice_note[5:0]),  32'd20);
    chk("s_idle",   32'(all_idle),         32'd0);
    step();
    chk("s_load_1cyc", 32'(voice_load),    32'd0);
    give_beat();
    chk("s_b1", 32'(voice_active), 32'd1);
    give_beat();
    chk("s_b2", 32'(voice_active), 32'd1);
    give_beat();
    chk("s_b3", 32'(voice_active), 32'd0);
    chk("s_idle_back", 32'(all_idle), 32'd1);

    // Chord 10/2, 14/4, 17/1
    give_note(6'd10, 6'd2);
    chk("c_a1", 32'(voice_active), 32'd1);
    give_note(6'd14, 6'd4);
    chk("c_a2", 32'(voice_active), 32'd3);
    chk("c_l2", 32'(voice_load),   32'd2);
    give_note(6'd17, 6'd1);
    chk("c_a3", 32'(voice_active), 32'd7);
    chk("c_l3", 32'(voice_load),   32'd4);
    chk("c_ready", 32'(player_ready), 32'd0);
    chk("c_notes", 32'(voice_note), 32'((17 << 12) | (14 << 6) | 10));
    give_beat();
    chk("c_b1", 32'(voice_active), 32'd3);
    chk("c_ready1", 32'(player_ready), 32'd1);
    give_beat();
    chk("c_b2", 32'(voice_active), 32'd2);
    give_beat();
    chk("c_b3", 32'(voice_active), 32'd2);
    give_beat();
    chk("c_b4", 32'(voice_active), 32'd0);

    // Overflow
    give_note(6'd5, 6'd2);
    give_note(6'd6, 6'd2);
    give_note(6'd7, 6'd3);
    chk("o_full", 32'(voice_active), 32'd7);
    chk("o_pre",  32'(overflow),     32'd0);
    give_note(6'd30, 6'd2);
    chk("o_load", 32'(voice_load), 32'd0);
    chk("o_flag", 32'(overflow),   32'd1);
    chk("o_notes", 32'(voice_note), 32'((7 << 12) | (6 << 6) | 5));
    step();
    chk("o_sticky", 32'(overflow), 32'd1);
    give_beat(); give_beat();
    chk("o_drain2", 32'(voice_active), 32'd4);
    give_beat();
    chk("o_drain3", 32'(voice_active), 32'd0);
    chk("o_sticky2", 32'(overflow), 32'd1);

    // Same-cycle beat and new_note
    give_note(6'd9, 6'd1);
    chk("x_v0", 32'(voice_active), 32'd1);
    new_note = 1'b1; note = 6'd22; duration = 6'd2; beat = 1'b1;
    step();
    chk("x_active", 32'(voice_active),      32'd2);
    chk("x_load",   32'(voice_load),        32'd2);
    chk("x_note",   32'(voice_note[11:6]),  32'd22);
    give_beat();
    chk("x_b1", 32'(voice_active), 32'd2);
    give_beat();
    chk("x_b2", 32'(voice_active), 32'd0);

    // Pause
    give_note(6'd40, 6'd2);
    play = 1'b0;
    #1;
    chk("p_vplay0", 32'(voice_play),   32'd0);
    chk("p_act0",   32'(voice_active), 32'd1);
    for (int k = 0; k < 5; k++) give_beat();
    chk("p_frozen", 32'(voice_active), 32'd1);
    chk("p_vplay",  32'(voice_play),   32'd0);
    play = 1'b1;
    #1;
    chk("p_resume", 32'(voice_play), 32'd1);
    give_beat();
    chk("p_b1", 32'(voice_active), 32'd1);
    give_beat();
    chk("p_b2", 32'(voice_active), 32'd0);

    // Reset clears overflow; duration 0 is ignored
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("e_ovf_clr", 32'(overflow), 32'd0);
    give_note(6'd12, 6'd0);
    chk("e_d0_load", 32'(voice_load),   32'd0);
    chk("e_d0_act",  32'(voice_active), 32'd0);
    chk("e_d0_ovf",  32'(overflow),     32'd0);

    // Rest note occupies a voice
    give_note(6'd0, 6'd1);
    chk("r_act",  32'(voice_active), 32'd1);
    chk("r_load", 32'(voice_load),   32'd1);
    give_beat();
    chk("r_free", 32'(voice_active), 32'd0);

    // Reset with two voices active and a concurrent new_note
    give_note(6'd1, 6'd5);
    give_note(6'd2, 6'd5);
    chk("m_two", 32'(voice_active), 32'd3);
    reset = 1'b1; new_note = 1'b1; note = 6'd3; duration = 6'd5;
    step();
    reset = 1'b0;
    chk("m_active", 32'(voice_active), 32'd0);
    chk("m_load",   32'(voice_load),   32'd0);
    chk("m_note",   32'(voice_note),   32'd0);
    chk("m_ready",  32'(player_ready), 32'd1);
    chk("m_idle",   32'(all_idle),     32'd1);
    chk("m_ovf",    32'(overflow),     32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
